if_prefetch: RTL

Parametrised instruction-fetch stage that replaces the single-word, zero-latency IRAM fetch with a bus-attached prefetcher. It issues sequential fetch requests on a req/gnt instruction bus with variable response latency and buffers returned words, with their PCs, in a FIFO. On a branch/jump it flushes and discards stale in-flight responses. It reports misaligned-target and bus-error exceptions per instruction, sits between the branch unit (bj_flag/bj_addr) and the decode stage, and hands instructions over with a valid/ready handshake.

---
 rtl/if_prefetch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: bus-attached instruction prefetch stage.
// Issues sequential req/gnt fetches, buffers words with PCs, flushes on redirect.
module if_prefetch #(
    parameter int              XLEN            = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bj_flag,
    input  logic [XLEN-1:0] bj_addr,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_gnt,
    input  logic            ibus_rvalid,
    input  logic [XLEN-1:0] ibus_rdata,
    input  logic            ibus_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            if_inst_addr_misal,
    output logic            if_inst_access_fault
);

    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = FPW + 1;
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
    localparam logic [PW-1:0]   MAX_P    = PW'(MAX_OUTSTANDING);
    localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [TPW-1:0]  TAG_LAST = TPW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        S_RUN,
        S_MISAL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] misal_pc_q, misal_pc_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic [PW-1:0]   discard_q, discard_d;

    logic [XLEN-1:0] tag_mem_q [MAX_OUTSTANDING];
    logic [XLEN-1:0] tag_mem_d [MAX_OUTSTANDING];
    logic [TPW-1:0]  tag_wr_q, tag_wr_d;
    logic [TPW-1:0]  tag_rd_q, tag_rd_d;

    logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_d   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_inst_d [FIFO_DEPTH];
    logic            fifo_flt_q  [FIFO_DEPTH];
    logic            fifo_flt_d  [FIFO_DEPTH];
    logic [FPW-1:0]  fifo_wr_q, fifo_wr_d;
    logic [FPW-1:0]  fifo_rd_q, fifo_rd_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic [CW:0] occupancy;
    logic        grant;
    logic        rsp;
    logic        push;
    logic        pop;

    // Request only when every in-flight word already has a reserved FIFO slot.
    always_comb begin
        occupancy = (CW + 1)'(fifo_cnt_q) + (CW + 1)'(pending_q);
        ibus_req  = !rst && (state_q == S_RUN) && !bj_flag &&
                    (pending_q < MAX_P) && (occupancy < DEPTH_C);
        ibus_addr = fetch_pc_q;
        grant     = ibus_req && ibus_gnt;
        rsp       = ibus_rvalid && (pending_q != '0);
        push      = rsp && (discard_q == '0);
        pop       = (state_q == S_RUN) && (fifo_cnt_q != '0) && if_ready;
    end

    // Head presentation: synthetic NOP while parked on a misaligned target.
    always_comb begin
        if (state_q == S_MISAL) begin
            if_valid             = 1'b1;
            if_pc                = misal_pc_q;
            if_inst              = NOP_INST;
            if_inst_addr_misal   = 1'b1;
            if_inst_access_fault = 1'b0;
        end else begin
            if_valid             = (fifo_cnt_q != '0);
            if_pc                = fifo_pc_q[fifo_rd_q];
            if_inst              = fifo_inst_q[fifo_rd_q];
            if_inst_addr_misal   = 1'b0;
            if_inst_access_fault = fifo_flt_q[fifo_rd_q];
        end
    end

    // Next-state: issue, response pairing, FIFO traffic and redirect flush.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        misal_pc_d  = misal_pc_q;
        pending_d   = pending_q;
        discard_d   = discard_q;
        tag_mem_d   = tag_mem_q;
        tag_wr_d    = tag_wr_q;
        tag_rd_d    = tag_rd_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        fifo_flt_d  = fifo_flt_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;

        if (grant) begin
            tag_mem_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d   = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (rsp) begin
            tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + 1'b1;
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end
        end

        case ({grant, rsp})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase

        if (push) begin
            fifo_pc_d[fifo_wr_q]   = tag_mem_q[tag_rd_q];
            fifo_inst_d[fifo_wr_q] = ibus_rdata;
            fifo_flt_d[fifo_wr_q]  = ibus_err;
            fifo_wr_d              = fifo_wr_q + 1'b1;
        end

        if (pop) begin
            fifo_rd_d = fifo_rd_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // No grant can occur this cycle, so every remaining request is stale.
        if (bj_flag) begin
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            discard_d  = pending_d;
            fetch_pc_d = {bj_addr[XLEN-1:2], 2'b00};
            misal_pc_d = bj_addr;
            state_d    = (bj_addr[1:0] != 2'b00) ? S_MISAL : S_RUN;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            misal_pc_q <= '0;
            pending_q  <= '0;
            discard_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
                fifo_flt_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            misal_pc_q  <= misal_pc_d;
            pending_q   <= pending_d;
            discard_q   <= discard_d;
            tag_mem_q   <= tag_mem_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_flt_q  <= fifo_flt_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // A response with nothing outstanding is a bus protocol violation.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(ibus_rvalid && (pending_q == '0)));
        end
    end

endmodule
